inst_fetcher: RTL and testbench
===============================

Name: inst_fetcher

Overview:
Instruction-fetch front end that initiates requests on the cache controller's fetch port: drives pc/start_fetch, consumes fetch_ready/inst/inst_addr. Fetched words go into a small circular instruction queue feeding the decoder. The block predicts JAL targets statically and redirects to clear_pc on rob_clear_up.

Parameters:
QUEUE_LOG, 2, log2 of queue depth (DEPTH = 2^QUEUE_LOG = 4 entries)
RESET_PC, 32'h0, pc loaded on reset

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous reset, active-high
rdy_in  input  1  global ready; when low all state holds
rob_clear_up  input  1  pipeline flush / redirect
clear_pc  input  32  redirect target, valid with rob_clear_up
start_fetch  output  1  fetch request to cache controller (registered)
pc  output  32  fetch address (registered)
fetch_ready  input  1  response valid (may be same cycle as start_fetch on icache hit)
inst  input  32  fetched instruction
inst_addr  input  32  address of fetched instruction
dec_valid  output  1  queue head valid (count != 0)
dec_inst  output  32  head instruction
dec_pc  output  32  head instruction address
dec_pred_pc  output  32  predicted next pc of head
dec_ready  input  1  decoder consumes head when dec_valid && dec_ready

Behaviour:
- Reset (rst_in=1 at posedge): pc=RESET_PC, start_fetch=0, head=tail=0, count=0, dec_valid=0. Queue data and outputs other than dec_valid are don't-care while empty. rst_in overrides rdy_in and rob_clear_up.
- rdy_in=0: no register changes; pop/push suppressed; outputs hold.
- Precedence each rdy cycle: reset > rob_clear_up > normal.
- Flush (rob_clear_up=1): count=0, head=tail=0, pc<=clear_pc, start_fetch<=0. Any fetch_ready that cycle is discarded. Pop that cycle is void. start_fetch re-asserts on the next cycle (one-cycle bubble).
- Accept condition: start_fetch && fetch_ready && inst_addr==pc. A response with inst_addr!=pc is stale: ignore it, keep start_fetch and pc unchanged.
- On accept:
  - Push {inst, pc, next_pc} at tail; tail wraps mod DEPTH.
  - pc<=next_pc.
- next_pc:
  - If inst[6:0]==7'b1101111 (JAL): pc + sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - Otherwise pc+4.
  - All arithmetic is 32-bit, wrapping mod 2^32.
- Pop: dec_valid && dec_ready advances head (wraps mod DEPTH).
- count_next = count + push - pop; count width QUEUE_LOG+1.
- start_fetch_next = (count_next < DEPTH) in normal cycles. start_fetch stays high across a multi-cycle miss until accept; it never drops mid-request except on flush or reset.
- Push never happens when count==DEPTH: start_fetch is 0 whenever full. Simultaneous push and pop at count==DEPTH-1 keeps count unchanged and start_fetch=1.
- Pop on empty is impossible (dec_valid=0).
- dec_* are combinational from queue[head]; FIFO order is preserved.

Test Plan:
- Reset then icache-hit stream (fetch_ready same cycle, inst=32'h00000013, inst_addr=pc), dec_ready=1 -> dec_pc sequence 0,4,8,C one per cycle; start_fetch stays 1.
- dec_ready=0, every fetch hits -> 4 entries queued (pcs 0,4,8,C); start_fetch=0 with pc=0x10. Raise dec_ready for 1 cycle -> head pops, start_fetch=1 next cycle, then fills again.
- JAL at pc=0x100, inst=32'h0080006F (imm +8) -> next pc=0x108, dec_pred_pc=0x108. Backward JAL 32'hFF9FF06F at 0x108 -> pc=0x100.
- Miss: fetch_ready low for 10 cycles -> start_fetch and pc=0x20 held constant. Response with inst_addr=0x40 -> ignored. Response with inst_addr=0x20 -> pushed.
- 3 entries queued, then rob_clear_up=1 with clear_pc=0x2000 and simultaneous fetch_ready -> next cycle dec_valid=0, pc=0x2000, start_fetch=0. Following cycle start_fetch=1 and first accepted dec_pc=0x2000.
- rdy_in=0 for 5 cycles mid-miss with fetch_ready=1, dec_ready=1 -> no push/pop, pc/count unchanged. Assert rst_in while 2 entries queued -> count=0, pc=RESET_PC next cycle.

Source files
------------

// File: rtl/inst_fetcher.sv
// Instruction fetch front end: issues pc/start_fetch to the icache, queues fetched words for decode.
// Latency: a response accepted at a clock edge appears at dec_* after that edge; an icache hit sustains one word per cycle.
// Backpressure: start_fetch drops while the 2^QUEUE_LOG-entry queue is full; rdy_in low freezes every register.
module inst_fetcher #(
  parameter int          QUEUE_LOG = 2,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_clear_up,
  input  logic [31:0] clear_pc,
  output logic        start_fetch,
  output logic [31:0] pc,
  input  logic        fetch_ready,
  input  logic [31:0] inst,
  input  logic [31:0] inst_addr,
  output logic        dec_valid,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_pred_pc,
  input  logic        dec_ready
);

  localparam int DEPTH = 1 << QUEUE_LOG;
  localparam int PTR_W = QUEUE_LOG;
  localparam int CNT_W = QUEUE_LOG + 1;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pred_pc;
  } entry_t;

  entry_t             queue [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;

  logic               is_jal;
  logic [31:0]        jal_imm;
  logic [31:0]        next_pc;
  logic               push;
  logic               pop;
  logic [CNT_W-1:0]   count_next;
  entry_t             head_entry;

  // Static next-pc prediction for the word being returned, plus push/pop bookkeeping.
  always_comb begin
    is_jal     = (inst[6:0] == 7'b1101111);
    jal_imm    = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    next_pc    = is_jal ? (pc + jal_imm) : (pc + 32'd4);
    // A response for any address other than pc belongs to an abandoned request.
    push       = start_fetch && fetch_ready && (inst_addr == pc);
    pop        = dec_valid && dec_ready;
    count_next = count + CNT_W'(push) - CNT_W'(pop);
  end

  // Decoder sees the queue head directly; contents are meaningless while empty.
  always_comb begin
    head_entry  = queue[head];
    dec_valid   = (count != '0);
    dec_inst    = head_entry.inst;
    dec_pc      = head_entry.pc;
    dec_pred_pc = head_entry.pred_pc;
  end

  // Control state: reset beats flush beats normal fetch/decode traffic.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc          <= RESET_PC;
      start_fetch <= 1'b0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else if (rdy_in) begin
      if (rob_clear_up) begin
        // Dropping start_fetch for one cycle lets the cache retire any request in flight.
        pc          <= clear_pc;
        start_fetch <= 1'b0;
        head        <= '0;
        tail        <= '0;
        count       <= '0;
      end else begin
        if (push) begin
          pc   <= next_pc;
          tail <= tail + PTR_W'(1);
        end
        if (pop) begin
          head <= head + PTR_W'(1);
        end
        count       <= count_next;
        // While a request is outstanding the queue cannot fill, so this never
        // drops start_fetch mid-request.
        start_fetch <= (count_next < CNT_W'(DEPTH));
      end
    end
  end

  // Queue storage: written only on an accepted response, never reset.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && !rob_clear_up && push) begin
      queue[tail] <= '{inst: inst, pc: pc, pred_pc: next_pc};
    end
  end

endmodule

// File: tb/tb_inst_fetcher.sv
// Self-checking bench for inst_fetcher: vector table, directed corner sequences, random traffic vs a queue model.
module tb_inst_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        rob_clear_up = 1'b0;
  logic [31:0] clear_pc = 32'h0;
  logic        start_fetch;
  logic [31:0] pc;
  logic        fetch_ready = 1'b0;
  logic [31:0] inst = 32'h13;
  logic [31:0] inst_addr = 32'h0;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic [31:0] dec_pred_pc;
  logic        dec_ready = 1'b0;

  inst_fetcher #(.QUEUE_LOG(2), .RESET_PC(32'h0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .rob_clear_up(rob_clear_up), .clear_pc(clear_pc),
    .start_fetch(start_fetch), .pc(pc),
    .fetch_ready(fetch_ready), .inst(inst), .inst_addr(inst_addr),
    .dec_valid(dec_valid), .dec_inst(dec_inst), .dec_pc(dec_pc),
    .dec_pred_pc(dec_pred_pc), .dec_ready(dec_ready)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  // Reference model: a plain queue of decoded records plus the fetch pc.
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pred;
  } rec_t;

  rec_t        m_q[$];
  logic [31:0] m_pc = 32'h0;
  bit          m_sf = 1'b0;

  function automatic logic [31:0] pred_of(logic [31:0] p, logic [31:0] i);
    int off;
    if (i[6:0] == 7'b1101111) begin
      off = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
      return p + 32'(off);
    end
    return p + 32'd4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit   do_pop;
    bit   do_push;
    rec_t r;
    if (rst_in) begin
      m_q.delete(); m_pc = 32'h0; m_sf = 1'b0;
    end else if (rdy_in) begin
      if (rob_clear_up) begin
        m_q.delete(); m_pc = clear_pc; m_sf = 1'b0;
      end else begin
        do_pop  = (m_q.size() != 0) && dec_ready;
        do_push = m_sf && fetch_ready && (inst_addr == m_pc);
        if (do_pop) void'(m_q.pop_front());
        if (do_push) begin
          r.inst = inst; r.pc = m_pc; r.pred = pred_of(m_pc, inst);
          m_q.push_back(r);
          m_pc = r.pred;
        end
        m_sf = (m_q.size() < 4);
      end
    end
  endtask

  task automatic model_chk();
    chk("m_start_fetch", 32'(start_fetch), 32'(m_sf));
    chk("m_pc", pc, m_pc);
    chk("m_dec_valid", 32'(dec_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("m_dec_inst", dec_inst, m_q[0].inst);
      chk("m_dec_pc", dec_pc, m_q[0].pc);
      chk("m_dec_pred_pc", dec_pred_pc, m_q[0].pred);
    end
  endtask

  // One clock: inputs already stable, model follows the edge, outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk_in);
    model_edge();
    #1;
    model_chk();
  endtask

  task automatic idle();
    rst_in = 1'b0; rdy_in = 1'b1; rob_clear_up = 1'b0; fetch_ready = 1'b0; dec_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle(); rst_in = 1'b1; step(); rst_in = 1'b0;
  endtask

  task automatic hit(input logic [31:0] addr, input logic [31:0] word);
    fetch_ready = 1'b1; inst_addr = addr; inst = word; step();
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [31:0] addr;
    logic [31:0] r;

    // Vectors: each row is a hit at the previous row's pc, decoder always ready.
    tbl[0] = '{32'h00000013, 32'h00000004};
    tbl[1] = '{32'h00000013, 32'h00000008};
    tbl[2] = '{32'h0080006F, 32'h00000010};  // JAL +8
    tbl[3] = '{32'hFF9FF06F, 32'h00000008};  // JAL -8
    tbl[4] = '{32'h00000013, 32'h0000000C};
    tbl[5] = '{32'hFF1FF06F, 32'hFFFFFFFC};  // JAL -16 wraps below zero
    tbl[6] = '{32'h00000013, 32'h00000000};  // pc+4 wraps to zero
    tbl[7] = '{32'h0080006B, 32'h00000004};  // not JAL opcode

    // Reset state and first-request bubble.
    do_reset();
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_start_fetch", 32'(start_fetch), 32'd0);
    chk("rst_pc", pc, 32'h0);
    step();
    chk("post_rst_start_fetch", 32'(start_fetch), 32'd1);

    dec_ready = 1'b1;
    addr = 32'h0;
    for (int i = 0; i < 8; i++) begin
      hit(addr, tbl[i].inst);
      chk($sformatf("vec%0d_pc", i), pc, tbl[i].exp_pc);
      chk($sformatf("vec%0d_dec_pc", i), dec_pc, addr);
      chk($sformatf("vec%0d_pred", i), dec_pred_pc, tbl[i].exp_pc);
      chk($sformatf("vec%0d_sf", i), 32'(start_fetch), 32'd1);
      addr = tbl[i].exp_pc;
    end

    // Fill to full with the decoder stalled, then release one slot.
    do_reset(); step();
    for (int i = 0; i < 5; i++) hit(pc, 32'h00000013);
    chk("full_sf", 32'(start_fetch), 32'd0);
    chk("full_pc", pc, 32'h10);
    chk("full_head", dec_pc, 32'h0);
    dec_ready = 1'b1; hit(32'h10, 32'h13);
    chk("pop1_head", dec_pc, 32'h4);
    chk("pop1_sf", 32'(start_fetch), 32'd1);
    dec_ready = 1'b0; hit(32'h10, 32'h13);
    chk("refill_sf", 32'(start_fetch), 32'd0);
    chk("refill_pc", pc, 32'h14);

    // Flush with three queued entries and a coincident response.
    do_reset(); step();
    for (int i = 0; i < 3; i++) hit(pc, 32'h00000013);
    rob_clear_up = 1'b1; clear_pc = 32'h2000; hit(32'hC, 32'h13);
    rob_clear_up = 1'b0;
    chk("flush_valid", 32'(dec_valid), 32'd0);
    chk("flush_pc", pc, 32'h2000);
    chk("flush_sf", 32'(start_fetch), 32'd0);
    hit(32'h2000, 32'h13);
    chk("flush_bubble_sf", 32'(start_fetch), 32'd1);
    chk("flush_bubble_valid", 32'(dec_valid), 32'd0);
    hit(32'h2000, 32'h13);
    chk("flush_first_pc", dec_pc, 32'h2000);

    // Long miss at 0x20, stale response, then the real one.
    rob_clear_up = 1'b1; clear_pc = 32'h20; fetch_ready = 1'b0; step();
    rob_clear_up = 1'b0; step();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("miss_sf", 32'(start_fetch), 32'd1);
      chk("miss_pc", pc, 32'h20);
    end
    hit(32'h40, 32'h13);
    chk("stale_pc", pc, 32'h20);
    chk("stale_valid", 32'(dec_valid), 32'd0);
    hit(32'h20, 32'h13);
    chk("miss_push_pc", dec_pc, 32'h20);

    // Global stall with everything requesting activity.
    fetch_ready = 1'b0; step();
    rdy_in = 1'b0; dec_ready = 1'b1; fetch_ready = 1'b1; inst_addr = 32'h24;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_pc", pc, 32'h24);
      chk("stall_head", dec_pc, 32'h20);
    end
    rdy_in = 1'b1; dec_ready = 1'b0; fetch_ready = 1'b0;

    // Reset with two entries queued.
    hit(32'h24, 32'h13);
    chk("two_head", dec_pc, 32'h20);
    fetch_ready = 1'b0; rst_in = 1'b1; rob_clear_up = 1'b1; clear_pc = 32'h500; step();
    rst_in = 1'b0; rob_clear_up = 1'b0;
    chk("rst2_valid", 32'(dec_valid), 32'd0);
    chk("rst2_pc", pc, 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst_in       = ($urandom_range(0, 199) == 0);
      rdy_in       = ($urandom_range(0, 9) != 0);
      rob_clear_up = ($urandom_range(0, 39) == 0);
      clear_pc     = {$urandom_range(0, 65535), 16'h0} | 32'($urandom_range(0, 63) * 4);
      fetch_ready  = ($urandom_range(0, 9) < 6);
      inst_addr    = ($urandom_range(0, 9) == 0) ? m_pc + 32'd8 : m_pc;
      r            = $urandom;
      inst         = ($urandom_range(0, 9) < 3) ? {r[31:7], 7'b1101111} : r;
      dec_ready    = ($urandom_range(0, 1) == 1);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
